// File: rtl/rob_retire_pkg.sv
// Shared definitions for the ROB commit stage: head-entry layout, FSM encoding
// and the packing helper that flattens the retirement RAT onto one bus.
package rob_retire_pkg;
  localparam int PHYSREGS_DEPTH = 6;
  localparam int ARCHREGS       = 32;
  localparam int ROB_ENTRY_W    = PHYSREGS_DEPTH + 40;
  localparam int FLUSH_WAIT     = 3;
  localparam int RAT_W          = ARCHREGS * PHYSREGS_DEPTH;

  // Head entry field positions
  localparam int PHYS_LSB     = 0;
  localparam int ARCH_LSB     = PHYSREGS_DEPTH;
  localparam int DESTREQD_BIT = PHYSREGS_DEPTH + 5;
  localparam int MISPRED_BIT  = PHYSREGS_DEPTH + 6;
  localparam int STORE_BIT    = PHYSREGS_DEPTH + 7;
  localparam int TARGET_LSB   = PHYSREGS_DEPTH + 8;

  typedef logic [PHYSREGS_DEPTH-1:0] phys_t;

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_RECOVER = 2'd1,
    S_WAIT    = 2'd2
  } retire_state_t;

  // Arch register i lands at [i*PHYSREGS_DEPTH +: PHYSREGS_DEPTH]
  function automatic logic [RAT_W-1:0] packRat(input phys_t rat [ARCHREGS]);
    logic [RAT_W-1:0] flat;
    flat = '0;
    for (int i = 0; i < ARCHREGS; i++) begin
      flat[i*PHYSREGS_DEPTH +: PHYSREGS_DEPTH] = rat[i];
    end
    return flat;
  endfunction
endpackage

// File: rtl/rob_retire_rat.sv
// Retirement RAT: 32 arch->phys mappings, one write port, identity after reset,
// combinational read of one entry plus the whole table as a packed bus.
module retire_rat
  import rob_retire_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             wrEn,
  input  logic [4:0]       wrAddr,
  input  phys_t            wrData,
  input  logic [4:0]       rdAddr,
  output phys_t            rdData,
  output logic [RAT_W-1:0] ratFlat
);
  phys_t rat [ARCHREGS];

  // Phys 0..31 back the architectural state at reset; 32..63 start in the freelist
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < ARCHREGS; i++) begin
        rat[i] <= phys_t'(i);
      end
    end else if (wrEn) begin
      rat[wrAddr] <= wrData;
    end
  end

  assign rdData  = rat[rdAddr];
  assign ratFlat = packRat(rat);
endmodule

// File: rtl/rob_retire.sv
// In-order commit at the ROB head: updates the retirement RAT, frees superseded
// phys regs, releases stores, and restores REN's RAT / flushes on a mispredict.
module rob_retire
  import rob_retire_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   FREEZE,
  input  logic                   fROB_empty_IN,
  input  logic                   fROB_headDone_IN,
  input  logic [ROB_ENTRY_W-1:0] fROB_headData_IN,
  output logic                   tROB_popReq_OUT,
  input  logic                   fFreeL_full_IN,
  output logic                   tFreeL_pushReq_OUT,
  output phys_t                  tFreeL_pushData_OUT,
  output logic                   tRenRatOverwrite_OUT,
  output logic [RAT_W-1:0]       tRenRatOverwriteData_OUT,
  output logic                   tLSQ_commitReq_OUT,
  output logic                   tFlush_OUT,
  output logic [31:0]            tRedirectPC_OUT,
  output logic [31:0]            retireCount_OUT,
  output logic [1:0]             debugState_OUT
);
  localparam int CNT_W = $clog2(FLUSH_WAIT + 1);

  // Handshake: the head leaves the ROB in the same cycle tROB_popReq_OUT is high;
  // the ROB has already qualified the head with !empty and headDone.
  retire_state_t    state, stateNext;
  logic [CNT_W-1:0] waitCnt, waitCntNext;
  logic             pop;
  logic             recoverPulse;

  phys_t       physDest;
  logic [4:0]  archDest;
  logic        destReqd, mispredict, isStore;
  logic [31:0] target;
  phys_t       oldPhys;
  logic        ratWr;

  assign physDest   = fROB_headData_IN[PHYS_LSB +: PHYSREGS_DEPTH];
  assign archDest   = fROB_headData_IN[ARCH_LSB +: 5];
  assign destReqd   = fROB_headData_IN[DESTREQD_BIT];
  assign mispredict = fROB_headData_IN[MISPRED_BIT];
  assign isStore    = fROB_headData_IN[STORE_BIT];
  assign target     = fROB_headData_IN[TARGET_LSB +: 32];

  // Writes to arch 0 are discarded, so its new phys reg goes straight back
  assign ratWr = pop && destReqd && (archDest != 5'd0);

  retire_rat u_rat (
    .CLK     (CLK),
    .RESET   (RESET),
    .wrEn    (ratWr),
    .wrAddr  (archDest),
    .wrData  (physDest),
    .rdAddr  (archDest),
    .rdData  (oldPhys),
    .ratFlat (tRenRatOverwriteData_OUT)
  );

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    pop         = 1'b0;
    case (state)
      S_RUN: begin
        pop = !RESET && !FREEZE && !fROB_empty_IN && fROB_headDone_IN
              && !(destReqd && fFreeL_full_IN);
        if (pop && mispredict) stateNext = S_RECOVER;
      end
      S_RECOVER: begin
        if (!FREEZE) begin
          stateNext   = S_WAIT;
          waitCntNext = CNT_W'(FLUSH_WAIT);
        end
      end
      S_WAIT: begin
        if (!FREEZE) begin
          waitCntNext = waitCnt - CNT_W'(1);
          if (waitCnt <= CNT_W'(1)) stateNext = S_RUN;
        end
      end
      default: stateNext = S_RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state               <= S_RUN;
      waitCnt             <= '0;
      tFreeL_pushReq_OUT  <= 1'b0;
      tFreeL_pushData_OUT <= '0;
      tLSQ_commitReq_OUT  <= 1'b0;
      recoverPulse        <= 1'b0;
      tRedirectPC_OUT     <= '0;
      retireCount_OUT     <= '0;
    end else begin
      state               <= stateNext;
      waitCnt             <= waitCntNext;
      tFreeL_pushReq_OUT  <= pop && destReqd;
      tFreeL_pushData_OUT <= (pop && destReqd) ? ((archDest != 5'd0) ? oldPhys : physDest) : '0;
      tLSQ_commitReq_OUT  <= pop && isStore;
      recoverPulse        <= pop && mispredict;
      tRedirectPC_OUT     <= (pop && mispredict) ? target : '0;
      if (pop) retireCount_OUT <= retireCount_OUT + 32'd1;
    end
  end

  // The RAT already holds the branch's own update while the strobe is high
  assign tROB_popReq_OUT      = pop;
  assign tFlush_OUT           = recoverPulse;
  assign tRenRatOverwrite_OUT = recoverPulse;
  assign debugState_OUT       = state;
endmodule
